// File: rtl/sync_fifo_pkg.sv
// Shared defaults and depth helper for the synchronous FIFO.
package sync_fifo_pkg;
    localparam int DEF_WIDTH   = 8;
    localparam int DEF_POINTER = 4;

    function automatic int fifo_depth(input int pointer);
        return 1 << pointer;
    endfunction
endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port RAM: synchronous write, read port registered by default or
// asynchronous when SYNC_FIFO_FWFT_EN is defined.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int POINTER = DEF_POINTER
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we_i,
    input  logic [POINTER-1:0] waddr_i,
    input  logic [WIDTH-1:0]   wdata_i,
    input  logic               re_i,
    input  logic [POINTER-1:0] raddr_i,
    output logic [WIDTH-1:0]   rdata_o
);
    localparam int DEPTH = fifo_depth(POINTER);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage is deliberately not reset; the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

`ifdef SYNC_FIFO_FWFT_EN
    logic unused_rd_ctrl;
    assign unused_rd_ctrl = reset ^ re_i;
    assign rdata_o        = mem_q[raddr_i];
`else
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (reset)     rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
`endif
endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count, threshold flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int POINTER  = DEF_POINTER,
    parameter int AF_LEVEL = fifo_depth(POINTER) - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [WIDTH-1:0]   data_in,
    input  logic               rd_en,
    output logic [WIDTH-1:0]   data_out,
    output logic               data_valid,
    output logic               full,
    output logic               empty,
    output logic               almost_full,
    output logic               almost_empty,
    output logic [POINTER:0]   count,
    output logic               overflow,
    output logic               underflow
);
    localparam logic [POINTER:0] AF_L = (POINTER+1)'(AF_LEVEL);
    localparam logic [POINTER:0] AE_L = (POINTER+1)'(AE_LEVEL);

    logic [POINTER:0] wr_ptr_q, wr_ptr_d;
    logic [POINTER:0] rd_ptr_q, rd_ptr_d;
    logic [POINTER:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             wr_acc, rd_acc;
    logic [WIDTH-1:0] rdata;

    // Same address bits with differing MSB means the writer lapped the reader.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[POINTER-1:0] == rd_ptr_q[POINTER-1:0]) &&
                   (wr_ptr_q[POINTER] != rd_ptr_q[POINTER]);

    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
        if (wr_acc && !rd_acc) count_d = count_q + 1'b1;
        if (rd_acc && !wr_acc) count_d = count_q - 1'b1;
        if (wr_en && full)  ovf_d = 1'b1;
        if (rd_en && empty) udf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    assign count        = count_q;
    assign almost_full  = (count_q >= AF_L);
    assign almost_empty = (count_q <= AE_L);
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    sync_fifo_mem #(.WIDTH(WIDTH), .POINTER(POINTER)) u_mem (
        .clk     (clk),
        .reset   (reset),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q[POINTER-1:0]),
        .wdata_i (data_in),
        .re_i    (rd_acc),
        .raddr_i (rd_ptr_q[POINTER-1:0]),
        .rdata_o (rdata)
    );

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is forced to zero while nothing is stored so reset reads as 0.
    assign data_out   = empty ? '0 : rdata;
    assign data_valid = !empty;
`else
    logic dv_q;

    always_ff @(posedge clk) begin
        if (reset) dv_q <= 1'b0;
        else       dv_q <= rd_acc;
    end

    assign data_out   = rdata;
    assign data_valid = dv_q;
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// Randomized and directed bench for sync_fifo against a queue-based model.
module tb_sync_fifo;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       data_valid, full, empty, almost_full, almost_empty;
    logic [4:0] count;
    logic       overflow, underflow;

    int errors = 0;
    int checks = 0;

    sync_fifo #(.WIDTH(8), .POINTER(4), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(data_out), .data_valid(data_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: contents as a queue, flags from plain arithmetic.
    logic [7:0] mq [$];
    logic [7:0] popped [$];
    logic       m_ovf = 1'b0, m_udf = 1'b0, m_dv = 1'b0;
    logic [7:0] m_dout = 8'h00;
    logic       cw, cr, m_full, m_empty;
    logic [7:0] cd, val;

    always @(posedge clk) begin
        cw = wr_en; cr = rd_en; cd = data_in;
`ifdef SYNC_FIFO_FWFT_EN
        if (!reset && cr && !empty) popped.push_back(data_out);
`endif
        if (reset) begin
            mq.delete();
            m_ovf = 1'b0; m_udf = 1'b0; m_dv = 1'b0; m_dout = 8'h00;
        end else begin
            m_full  = (mq.size() == 16);
            m_empty = (mq.size() == 0);
            if (cw && m_full)  m_ovf = 1'b1;
            if (cr && m_empty) m_udf = 1'b1;
            m_dv = 1'b0;
            if (cr && !m_empty) begin
                val = mq.pop_front();
                m_dout = val;
                m_dv = 1'b1;
            end
            if (cw && !m_full) mq.push_back(cd);
        end
`ifdef SYNC_FIFO_FWFT_EN
        m_dv   = (mq.size() != 0);
        m_dout = m_dv ? mq[0] : 8'h00;
`endif
        #1;
`ifndef SYNC_FIFO_FWFT_EN
        if (data_valid) popped.push_back(data_out);
`endif
        chk("count",        32'(count),        32'(mq.size()));
        chk("full",         32'(full),         32'(mq.size() == 16));
        chk("empty",        32'(empty),        32'(mq.size() == 0));
        chk("almost_full",  32'(almost_full),  32'(mq.size() >= 14));
        chk("almost_empty", 32'(almost_empty), 32'(mq.size() <= 2));
        chk("overflow",     32'(overflow),     32'(m_ovf));
        chk("underflow",    32'(underflow),    32'(m_udf));
        chk("data_valid",   32'(data_valid),   32'(m_dv));
        chk("data_out",     32'(data_out),     32'(m_dout));
    end

    task automatic step(input logic rst, input logic w, input logic r, input logic [7:0] d);
        @(negedge clk);
        reset = rst; wr_en = w; rd_en = r; data_in = d;
    endtask

    task automatic settle();
        @(negedge clk);
        reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        int bad;
        int pw, pr;
        step(1, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00);
        settle();
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_ae",    32'(almost_empty), 1);
        chk("rst_dout",  32'(data_out), 0);

        // Fill with 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 0, 8'(i));
`ifdef SYNC_FIFO_FWFT_EN
            if (i == 0) begin
                settle();
                chk("fwft_first_dv",   32'(data_valid), 1);
                chk("fwft_first_data", 32'(data_out), 0);
            end
`endif
        end
        settle();
        chk("fill_count", 32'(count), 16);
        chk("fill_full",  32'(full), 1);
        chk("fill_af",    32'(almost_full), 1);
        chk("fill_ovf",   32'(overflow), 0);

        step(0, 1, 0, 8'hAA);
        settle();
        chk("ovf_set",   32'(overflow), 1);
        chk("ovf_count", 32'(count), 16);

        popped.delete();
        for (int i = 0; i < 16; i++) step(0, 0, 1, 8'h00);
        settle();
        chk("drain_n",     32'(popped.size()), 16);
        bad = 0;
        foreach (popped[i]) if (popped[i] !== 8'(i)) bad++;
        chk("drain_order", 32'(bad), 0);
        chk("drain_empty", 32'(empty), 1);
        chk("ovf_sticky",  32'(overflow), 1);

        // Underflow on empty after reset
        step(1, 0, 0, 8'h00);
        step(0, 0, 1, 8'h00);
        settle();
        chk("udf_set",   32'(underflow), 1);
        chk("udf_dv",    32'(data_valid), 0);
        chk("udf_count", 32'(count), 0);

        // Steady-state streaming at count 8 across pointer wrap
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 8'(8'h10 + i));
        popped.delete();
        for (int i = 0; i < 40; i++) step(0, 1, 1, 8'(8'h18 + i));
        settle();
        chk("wrap_count", 32'(count), 8);
        chk("wrap_n",     32'(popped.size()), 40);
        bad = 0;
        foreach (popped[i]) if (popped[i] !== 8'(8'h10 + i)) bad++;
        chk("wrap_order", 32'(bad), 0);

        // Reset with wr_en high at count 10 discards everything
        for (int i = 0; i < 2; i++) step(0, 1, 0, 8'(8'h60 + i));
        step(1, 1, 0, 8'h99);
        settle();
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_empty", 32'(empty), 1);
        chk("mid_rst_ovf",   32'(overflow), 0);
        chk("mid_rst_udf",   32'(underflow), 0);
        step(0, 1, 0, 8'h55);
        popped.delete();
        step(0, 0, 1, 8'h00);
        settle();
        chk("mid_rst_first", 32'(popped.size() > 0 ? popped[0] : 8'hxx), 32'h55);

        // Random traffic in phases biased toward full, empty and balanced
        for (int ph = 0; ph < 6; ph++) begin
            pw = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 20 : 50;
            pr = 100 - pw;
            for (int i = 0; i < 150; i++)
                step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < pw,
                     $urandom_range(0, 99) < pr, 8'($urandom));
        end
        settle();
        settle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
